// File: rtl/vga_frame_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_frame_capture_pkg
//  Description : Shared types and constants for the VGA frame capture block:
//                capture FSM state type, active-area size, pixel width and a
//                frame-start decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_frame_capture_pkg;

    // Capture controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

    // Active video area of the 1024x768 timing this block snoops
    localparam int H_ACTIVE = 1024;
    localparam int V_ACTIVE = 768;

    // Pixel width, {r,g,b} at 4 bits each
    localparam int RGB_W = 12;

    // Width of the hcount/vcount counters on the video stream
    localparam int CNT_W = 11;

    // A frame begins at the top-left pixel; compared at the full counter width
    function automatic logic is_frame_start(input logic [CNT_W-1:0] hcount,
                                            input logic [CNT_W-1:0] vcount);
        return (hcount == '0) && (vcount == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_frame_capture_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_if
//  Description : VGA pixel stream bundle: position counters, syncs, blanking
//                flags and pixel colour. The source drives the master side and
//                observers such as the frame capture take the slave side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_if;
    import vga_frame_capture_pkg::*;

    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;

    modport master (
        output hcount,
        output vcount,
        output hsync,
        output vsync,
        output hblnk,
        output vblnk,
        output rgb
    );

    modport slave (
        input hcount,
        input vcount,
        input hsync,
        input vsync,
        input hblnk,
        input vblnk,
        input rgb
    );

endinterface
`default_nettype wire

// File: rtl/vga_frame_capture_window.sv
`default_nettype none
// ============================================================================
//  Module      : capture_window
//  Description : Combinational window decode. Flags a pixel that is inside the
//                visible area and inside the rectangle [X0, X0+WIDTH) x
//                [Y0, Y0+HEIGHT) of the stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module capture_window
    import vga_frame_capture_pkg::*;
#(
    parameter int X0     = 0,
    parameter int Y0     = 0,
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 96
) (
    input  wire logic [CNT_W-1:0] i_hcount,
    input  wire logic [CNT_W-1:0] i_vcount,
    input  wire logic             i_hblnk,
    input  wire logic             i_vblnk,
    output logic                  o_hit
);

    // Window origin and extent held at 12 bits so the window end can never
    // overflow, however close to the right/bottom edge the window is placed.
    localparam logic [CNT_W:0] c_X0     = (CNT_W + 1)'(X0);
    localparam logic [CNT_W:0] c_Y0     = (CNT_W + 1)'(Y0);
    localparam logic [CNT_W:0] c_WIDTH  = (CNT_W + 1)'(WIDTH);
    localparam logic [CNT_W:0] c_HEIGHT = (CNT_W + 1)'(HEIGHT);

    logic [CNT_W:0] w_h_rel;
    logic [CNT_W:0] w_v_rel;
    logic           w_h_in;
    logic           w_v_in;

    // Range test as one unsigned compare per axis: a position left of / above
    // the origin wraps the 12-bit offset to >= 3073, which is never < extent,
    // so (pos - origin) < extent is exactly origin <= pos < origin + extent.
    always_comb begin
        w_h_rel = {1'b0, i_hcount} - c_X0;
        w_v_rel = {1'b0, i_vcount} - c_Y0;
        w_h_in  = (w_h_rel < c_WIDTH);
        w_v_in  = (w_v_rel < c_HEIGHT);
        o_hit   = !i_hblnk && !i_vblnk && w_h_in && w_v_in;
    end

endmodule
`default_nettype wire

// File: rtl/vga_frame_capture.sv
`default_nettype none
// ============================================================================
//  Module      : vga_frame_capture
//  Description : Observe-only snooper on a VGA pixel stream. When armed, waits
//                for the next frame start and writes one rectangular window of
//                that frame into a pixel RAM, row-major from address 0, with a
//                one-cycle registered write port. Pulses done after the last
//                pixel; abort cancels at any time.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_capture
    import vga_frame_capture_pkg::*;
#(
    parameter int X0        = 0,
    parameter int Y0        = 0,
    parameter int WIDTH     = 128,
    parameter int HEIGHT    = 96,
    parameter int ADDR_BITS = 14
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 arm,
    input  wire logic                 abort,
    vga_if.slave                      in,
    output logic                      wr_en,
    output logic [ADDR_BITS-1:0]      wr_addr,
    output logic [RGB_W-1:0]          wr_data,
    output logic                      busy,
    output logic                      done
);

    // Address of the final window pixel; issuing it ends the capture
    localparam logic [ADDR_BITS-1:0] c_LAST_ADDR = ADDR_BITS'(WIDTH * HEIGHT - 1);

    cap_state_t             r_state;
    cap_state_t             w_state_next;
    logic [ADDR_BITS-1:0]   r_pix_cnt;
    logic [ADDR_BITS-1:0]   w_cnt_base;
    logic                   w_frame_start;
    logic                   w_in_window;
    logic                   w_capturing;
    logic                   w_restart;
    logic                   w_hit;
    logic                   r_wr_en;
    logic [ADDR_BITS-1:0]   r_wr_addr;
    logic [RGB_W-1:0]       r_wr_data;
    logic                   w_unused_sync;

    // Syncs are part of the snooped bundle but carry nothing this block needs
    assign w_unused_sync = in.hsync ^ in.vsync;

    assign w_frame_start = is_frame_start(in.hcount, in.vcount);

    capture_window #(
        .X0     (X0),
        .Y0     (Y0),
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_window (
        .i_hcount (in.hcount),
        .i_vcount (in.vcount),
        .i_hblnk  (in.hblnk),
        .i_vblnk  (in.vblnk),
        .o_hit    (w_in_window)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-cycle capture qualifiers. The frame-start
    // cycle already counts as capturing, so pixel (0,0) can land at address 0;
    // a frame start inside CAPTURE restarts the window from address 0.
    always_comb begin
        w_state_next = r_state;
        w_capturing  = 1'b0;
        w_restart    = 1'b0;
        w_hit        = 1'b0;
        w_cnt_base   = r_pix_cnt;

        case (r_state)
            IDLE: begin
                if (arm) begin
                    w_state_next = ARMED;
                end
            end
            ARMED: begin
                if (w_frame_start) begin
                    w_state_next = CAPTURE;
                    w_capturing  = 1'b1;
                    w_restart    = 1'b1;
                end
            end
            CAPTURE: begin
                w_capturing = 1'b1;
                w_restart   = w_frame_start;
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (w_restart) begin
            w_cnt_base = '0;
        end

        // Abort suppresses the write that would otherwise register this cycle
        w_hit = w_capturing && w_in_window && !abort;

        if (w_hit && (w_cnt_base == c_LAST_ADDR)) begin
            w_state_next = DONE;
        end

        // Abort outranks arm, frame start and completion
        if (abort) begin
            w_state_next = IDLE;
        end
    end

    // Pixel counter: running row-major address, one step per captured pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_cnt <= '0;
        end else if (w_hit) begin
            r_pix_cnt <= w_cnt_base + ADDR_BITS'(1);
        end else if (w_restart) begin
            r_pix_cnt <= '0;
        end
    end

    // Registered RAM write port, one cycle behind the hit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_hit;
            if (w_hit) begin
                r_wr_addr <= w_cnt_base;
                r_wr_data <= in.rgb;
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

    // Status straight from the state register: done rides with the final write
    // and busy is already low in that cycle.
    assign busy = (r_state == ARMED) || (r_state == CAPTURE);
    assign done = (r_state == DONE);

endmodule
`default_nettype wire
